capture_controller: RTL and testbench
=====================================

Name: capture_controller

Overview:
- Sequences ADC sample capture into the sample FIFO: arm, decimate, detect the trigger, record a fixed-length record, then report done.
- Sits between the ADC interface and the sample FIFO write port. The FIFO read side is drained separately by the PC streaming controller.
- Arm/abort pulses and trigger configuration come from the command decoder.

Parameters:
- DATA_SIZE, 12: ADC sample width in bits (unsigned codes).
- RECORD_LEN, 1024: samples per record, counting the trigger sample; must be >= 1.
- AUTO_TIMEOUT, 4096: decimated samples to wait in auto mode before forcing a trigger; must be >= 1.
- DECIM_WIDTH, 8: width of the decimation ratio input.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: asynchronous, active-low reset.
- adc_data_i, input, DATA_SIZE: ADC sample.
- adc_valid_i, input, 1: adc_data_i is valid this cycle.
- arm_i, input, 1: one-cycle pulse that starts a capture.
- abort_i, input, 1: one-cycle pulse that returns the block to IDLE.
- trig_level_i, input, DATA_SIZE: trigger threshold.
- trig_edge_i, input, 1: 0 = rising edge, 1 = falling edge.
- trig_auto_i, input, 1: 1 = auto mode (timeout forces a trigger), 0 = normal mode.
- decim_i, input, DECIM_WIDTH: keep one sample out of every decim_i+1 valid samples.
- fifo_full_i, input, 1: sample FIFO is full.
- fifo_data_o, output, DATA_SIZE: sample written to the FIFO.
- fifo_write_en_o, output, 1: FIFO write strobe.
- busy_o, output, 1: high in ARMED or CAPTURE.
- triggered_o, output, 1: high in CAPTURE or DONE.
- done_o, output, 1: high in DONE.
- overflow_o, output, 1: sticky flag; a record sample was dropped because the FIFO was full.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters, prev_valid and latched configuration cleared.
- States: IDLE, ARMED, CAPTURE, DONE.
- arm_i in IDLE or DONE:
  - go to ARMED;
  - latch trig_level_i, trig_edge_i, trig_auto_i and decim_i (input changes are ignored until the next arm);
  - clear decimation counter, prev_valid, timeout counter, record counter and overflow_o.
- arm_i in ARMED or CAPTURE is ignored.
- abort_i: highest priority, from any state go to IDLE next cycle. It also wins over a simultaneous arm_i, and any write that would have been issued is suppressed. overflow_o holds its value.
- Decimation (ARMED and CAPTURE only):
  - a sample is "accepted" when adc_valid_i=1 and the decimation counter is 0; the counter then reloads with the latched decim;
  - otherwise each valid sample decrements the counter;
  - the first valid sample after arm is always accepted;
  - decim=0 accepts every valid sample.
- Trigger condition (accepted sample in ARMED, prev_valid=1):
  - rising: prev < level and cur >= level;
  - falling: prev > level and cur <= level;
  - compares are unsigned.
  - Every accepted sample updates prev and sets prev_valid, so the first accepted sample after arm can never trigger.
- Auto mode: each accepted non-triggering sample in ARMED increments the timeout counter. The accepted sample that arrives when the counter equals AUTO_TIMEOUT-1 forces the trigger.
- On trigger (normal or forced):
  - the triggering sample is record sample 1 and is written;
  - record count = 1;
  - next state is CAPTURE, or DONE if RECORD_LEN = 1.
- CAPTURE: each accepted sample is written and the count increments. The accepted sample that brings the count to RECORD_LEN is written, and the next state is DONE.
- DONE: holds until arm_i or abort_i. No writes occur in IDLE or DONE.
- Write timing:
  - fifo_write_en_o and fifo_data_o are registered, one cycle after the accepting cycle;
  - the strobe is high for exactly one cycle per written sample.
- FIFO full:
  - if fifo_full_i=1 in the accepting cycle, no write is issued and overflow_o is set;
  - the record counter still advances, so the record stays time-aligned.
- Widths: record counter $clog2(RECORD_LEN+1) bits; timeout counter $clog2(AUTO_TIMEOUT+1) bits.

Decomposition:
- Shared package osc_pkg: state encodings (IDLE/ARMED/CAPTURE/DONE), EDGE_RISING/EDGE_FALLING, MODE_NORMAL/MODE_AUTO.
- One sub-module, capture_trigger_detect:
  - holds the prev register and prev_valid;
  - produces the edge-compare hit;
  - inputs: accepted-sample strobe, sample, level, edge, clear.

Test Plan:
- Rising trigger: RECORD_LEN=4, decim=0, level=0x800, normal mode, ramp 0x7F0,0x7F8,0x800,0x808,... -> first write is 0x800, then exactly 4 writes total, done_o high after the 4th, busy_o low.
- Falling/normal: edge=1, level=0x400, samples 0x500,0x3FF -> trigger on 0x3FF. A prior rising crossing must not trigger. A constant input never triggers in normal mode.
- Auto timeout: AUTO_TIMEOUT=8, auto mode, constant 0x100 -> 8th accepted sample forces the trigger and is the first write; triggered_o goes high.
- Decimation: decim=2, valid every cycle, data = index 0,1,2,... -> accepted samples are 0,3,6,...; written values match.
- FIFO full: fifo_full_i=1 on record samples 2 and 3 of 4 -> only samples 1 and 4 are written, overflow_o=1, done_o is asserted on schedule; re-arm clears overflow_o.
- Abort and reset mid-CAPTURE: abort_i together with arm_i -> IDLE and no further writes. rst_i low mid-record -> all outputs 0 immediately.

Source files
------------

// File: rtl/osc_pkg.sv
// ----------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscilloscope capture path.
//   state_t      : capture controller state encoding (IDLE/ARMED/CAPTURE/DONE)
//   EDGE_*       : trigger edge selection values
//   MODE_*       : trigger mode selection values
// ----------------------------------------------------------------------------
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  localparam logic MODE_NORMAL  = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/capture_trigger_detect.sv
// ----------------------------------------------------------------------------
// capture_trigger_detect
// Remembers the previously accepted sample and flags a threshold crossing
// between it and the current sample.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : forget the previous sample (new arm)
//   accept         : current sample is an accepted (decimated) sample
//   sample         : current sample
//   level          : trigger threshold (unsigned)
//   edge_sel       : EDGE_RISING / EDGE_FALLING
//   hit            : combinational; crossing between prev and sample
//                    (only meaningful together with accept)
// ----------------------------------------------------------------------------
module capture_trigger_detect
  import osc_pkg::*;
#(
  parameter int DATA_SIZE = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [DATA_SIZE-1:0] sample,
  input  logic [DATA_SIZE-1:0] level,
  input  logic                 edge_sel,
  output logic                 hit
);

  logic [DATA_SIZE-1:0] prev;
  logic                 prev_valid;

  // Unsigned crossing test between two consecutive accepted samples.
  function automatic logic crossed(input logic [DATA_SIZE-1:0] p,
                                   input logic [DATA_SIZE-1:0] c,
                                   input logic [DATA_SIZE-1:0] lvl,
                                   input logic                 falling);
    if (falling == EDGE_FALLING) begin
      return (p > lvl) && (c <= lvl);
    end
    return (p < lvl) && (c >= lvl);
  endfunction

  assign hit = prev_valid && crossed(prev, sample, level, edge_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/capture_controller.sv
// ----------------------------------------------------------------------------
// capture_controller
// Sequences ADC capture into the sample FIFO: arm, decimate, detect trigger,
// record RECORD_LEN samples (trigger sample included), then report done.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   adc_data_i/valid_i  : ADC sample stream
//   arm_i, abort_i      : one-cycle command pulses (abort has priority)
//   trig_level_i        : trigger threshold (unsigned)
//   trig_edge_i         : 0 rising, 1 falling
//   trig_auto_i         : 1 = timeout forces a trigger
//   decim_i             : keep one of every decim_i+1 valid samples
//   fifo_full_i         : sample FIFO full
//   fifo_data_o/_write_en_o : registered FIFO write port
//   busy_o, triggered_o, done_o : registered state indications
//   overflow_o          : sticky, a record sample was dropped on FIFO full
// ----------------------------------------------------------------------------
module capture_controller
  import osc_pkg::*;
#(
  parameter int DATA_SIZE    = 12,
  parameter int RECORD_LEN   = 1024,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int DECIM_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_SIZE-1:0]   adc_data_i,
  input  logic                   adc_valid_i,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [DATA_SIZE-1:0]   trig_level_i,
  input  logic                   trig_edge_i,
  input  logic                   trig_auto_i,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  input  logic                   fifo_full_i,
  output logic [DATA_SIZE-1:0]   fifo_data_o,
  output logic                   fifo_write_en_o,
  output logic                   busy_o,
  output logic                   triggered_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  localparam int REC_W = $clog2(RECORD_LEN + 1);
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECORD_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);

  state_t                 state;
  logic [DATA_SIZE-1:0]   level_q;
  logic                   edge_q;
  logic                   auto_q;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dec_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [REC_W-1:0]       rec_cnt;

  logic             active;
  logic             accept;
  logic             start;
  logic             hit;
  logic             force_trig;
  logic             fire;
  logic             rec_take;
  logic [REC_W-1:0] rec_next;
  logic             rec_last;

  assign active     = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign accept     = active && adc_valid_i && (dec_cnt == '0);
  // Arm only takes effect from an idle-ish state and never alongside abort.
  assign start      = arm_i && !abort_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign force_trig = (auto_q == MODE_AUTO) && (tmo_cnt == TMO_LAST);
  assign fire       = accept && (state == ST_ARMED) && (hit || force_trig);
  // A record sample is either the trigger sample or any accepted sample while
  // capturing; both share the write / count / completion path below.
  assign rec_take   = fire || (accept && (state == ST_CAPTURE));
  assign rec_next   = (state == ST_ARMED) ? REC_W'(1) : rec_cnt + REC_W'(1);
  assign rec_last   = (rec_next == REC_LAST);

  capture_trigger_detect #(
    .DATA_SIZE (DATA_SIZE)
  ) u_trig (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .clear    (start),
    .accept   (accept),
    .sample   (adc_data_i),
    .level    (level_q),
    .edge_sel (edge_q),
    .hit      (hit)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= ST_IDLE;
      level_q         <= '0;
      edge_q          <= EDGE_RISING;
      auto_q          <= MODE_NORMAL;
      decim_q         <= '0;
      dec_cnt         <= '0;
      tmo_cnt         <= '0;
      rec_cnt         <= '0;
      fifo_data_o     <= '0;
      fifo_write_en_o <= 1'b0;
      busy_o          <= 1'b0;
      triggered_o     <= 1'b0;
      done_o          <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      fifo_write_en_o <= 1'b0;

      if (abort_i) begin
        state       <= ST_IDLE;
        busy_o      <= 1'b0;
        triggered_o <= 1'b0;
        done_o      <= 1'b0;
      end else if (start) begin
        state       <= ST_ARMED;
        level_q     <= trig_level_i;
        edge_q      <= trig_edge_i;
        auto_q      <= trig_auto_i;
        decim_q     <= decim_i;
        dec_cnt     <= '0;
        tmo_cnt     <= '0;
        rec_cnt     <= '0;
        overflow_o  <= 1'b0;
        busy_o      <= 1'b1;
        triggered_o <= 1'b0;
        done_o      <= 1'b0;
      end else begin
        // Decimation: reload on accept, count down on other valid samples.
        if (active && adc_valid_i) begin
          dec_cnt <= accept ? decim_q : dec_cnt - DECIM_WIDTH'(1);
        end

        if (accept && (state == ST_ARMED) && !fire && (auto_q == MODE_AUTO)) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end

        if (rec_take) begin
          // Dropped samples still count so the record stays time-aligned.
          if (fifo_full_i) begin
            overflow_o <= 1'b1;
          end else begin
            fifo_write_en_o <= 1'b1;
            fifo_data_o     <= adc_data_i;
          end
          rec_cnt     <= rec_next;
          triggered_o <= 1'b1;
          if (rec_last) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state  <= ST_CAPTURE;
            busy_o <= 1'b1;
            done_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        arm = 1'b0;
  logic        abort_p = 1'b0;
  logic [11:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic        trig_auto = 1'b0;
  logic [7:0]  decim = '0;
  logic        fifo_full = 1'b0;
  logic [11:0] fifo_data;
  logic        fifo_we;
  logic        busy, trig, done, ovf;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        arm;
    logic        abort_p;
    logic        valid;
    logic [11:0] data;
    logic [11:0] level;
    logic        edge_s;
    logic        auto_m;
    logic [7:0]  decim;
    logic        ew;
    logic [11:0] ed;
    logic        eb;
    logic        et;
    logic        edn;
    logic        eo;
  } vec_t;

  vec_t tbl[$];
  logic [11:0] c_level = '0;
  logic        c_edge = 1'b0;
  logic        c_auto = 1'b0;
  logic [7:0]  c_decim = '0;

  capture_controller #(
    .DATA_SIZE    (12),
    .RECORD_LEN   (4),
    .AUTO_TIMEOUT (8),
    .DECIM_WIDTH  (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .adc_data_i      (adc_data),
    .adc_valid_i     (adc_valid),
    .arm_i           (arm),
    .abort_i         (abort_p),
    .trig_level_i    (trig_level),
    .trig_edge_i     (trig_edge),
    .trig_auto_i     (trig_auto),
    .decim_i         (decim),
    .fifo_full_i     (fifo_full),
    .fifo_data_o     (fifo_data),
    .fifo_write_en_o (fifo_we),
    .busy_o          (busy),
    .triggered_o     (trig),
    .done_o          (done),
    .overflow_o      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ew, input logic [11:0] ed,
                       input logic eb, input logic et, input logic edn, input logic eo);
    logic ok;
    n_vec++;
    ok = (fifo_we === ew) && (busy === eb) && (trig === et) && (done === edn) &&
         (ovf === eo) && (!ew || (fifo_data === ed));
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got we=%b data=%h busy=%b trig=%b done=%b ovf=%b, want we=%b data=%h busy=%b trig=%b done=%b ovf=%b",
               name, fifo_we, fifo_data, busy, trig, done, ovf, ew, ed, eb, et, edn, eo);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, check just after it.
  task automatic step(input string name, input logic a, input logic ab, input logic v,
                      input logic [11:0] d, input logic full,
                      input logic ew, input logic [11:0] ed,
                      input logic eb, input logic et, input logic edn, input logic eo);
    arm = a; abort_p = ab; adc_valid = v; adc_data = d; fifo_full = full;
    @(posedge clk);
    #1;
    check(name, ew, ed, eb, et, edn, eo);
  endtask

  function automatic void add(input string n, input logic a, input logic v, input logic [11:0] d,
                              input logic ew, input logic [11:0] ed,
                              input logic eb, input logic et, input logic edn);
    vec_t r;
    r.name = n; r.arm = a; r.abort_p = 1'b0; r.valid = v; r.data = d;
    r.level = c_level; r.edge_s = c_edge; r.auto_m = c_auto; r.decim = c_decim;
    r.ew = ew; r.ed = ed; r.eb = eb; r.et = et; r.edn = edn; r.eo = 1'b0;
    tbl.push_back(r);
  endfunction

  initial begin
    // Rising trigger, level 0x800, record of 4.
    c_level = 12'h800; c_edge = 1'b0; c_auto = 1'b0; c_decim = 8'd0;
    add("rise_arm",   1, 0, 12'h000, 0, 12'h000, 1, 0, 0);
    add("rise_7f0",   0, 1, 12'h7F0, 0, 12'h000, 1, 0, 0);
    add("rise_7f8",   0, 1, 12'h7F8, 0, 12'h000, 1, 0, 0);
    add("rise_800",   0, 1, 12'h800, 1, 12'h800, 1, 1, 0);
    add("rise_808",   0, 1, 12'h808, 1, 12'h808, 1, 1, 0);
    add("rise_gap",   0, 0, 12'h000, 0, 12'h000, 1, 1, 0);
    add("rise_810",   0, 1, 12'h810, 1, 12'h810, 1, 1, 0);
    add("rise_818",   0, 1, 12'h818, 1, 12'h818, 0, 1, 1);
    add("rise_hold",  0, 1, 12'h820, 0, 12'h000, 0, 1, 1);
    // Falling trigger, level 0x400; rising crossing and constant must not fire.
    c_level = 12'h400; c_edge = 1'b1;
    add("fall_arm",   1, 0, 12'h000, 0, 12'h000, 1, 0, 0);
    add("fall_300",   0, 1, 12'h300, 0, 12'h000, 1, 0, 0);
    add("fall_up500", 0, 1, 12'h500, 0, 12'h000, 1, 0, 0);
    add("fall_c500a", 0, 1, 12'h500, 0, 12'h000, 1, 0, 0);
    add("fall_c500b", 0, 1, 12'h500, 0, 12'h000, 1, 0, 0);
    add("fall_3ff",   0, 1, 12'h3FF, 1, 12'h3FF, 1, 1, 0);
    add("fall_3fe",   0, 1, 12'h3FE, 1, 12'h3FE, 1, 1, 0);
    add("fall_3fd",   0, 1, 12'h3FD, 1, 12'h3FD, 1, 1, 0);
    add("fall_3fc",   0, 1, 12'h3FC, 1, 12'h3FC, 0, 1, 1);
    // Auto mode: constant 0x100 never crosses; 8th accepted sample is forced.
    c_level = 12'h800; c_edge = 1'b0; c_auto = 1'b1;
    add("auto_arm",   1, 0, 12'h000, 0, 12'h000, 1, 0, 0);
    for (int i = 1; i <= 8; i++)
      add($sformatf("auto_s%0d", i), 0, 1, 12'h100, (i == 8), 12'h100, 1, (i == 8), 0);
    add("auto_r2",    0, 1, 12'h101, 1, 12'h101, 1, 1, 0);
    add("auto_r3",    0, 1, 12'h102, 1, 12'h102, 1, 1, 0);
    add("auto_r4",    0, 1, 12'h103, 1, 12'h103, 0, 1, 1);
    // Decimation by 3 on an index ramp; level 3 triggers on index 3.
    c_level = 12'h003; c_edge = 1'b0; c_auto = 1'b0; c_decim = 8'd2;
    add("dec_arm",    1, 0, 12'h000, 0, 12'h000, 1, 0, 0);
    for (int i = 0; i <= 12; i++)
      add($sformatf("dec_i%0d", i), 0, 1, 12'(i), (i >= 3 && i % 3 == 0), 12'(i),
          (i < 12), (i >= 3), (i == 12));

    #1;
    check("reset_state", 0, 12'h000, 0, 0, 0, 0);
    #11 rst_n = 1'b1;

    foreach (tbl[k]) begin
      trig_level = tbl[k].level; trig_edge = tbl[k].edge_s;
      trig_auto = tbl[k].auto_m; decim = tbl[k].decim;
      step(tbl[k].name, tbl[k].arm, tbl[k].abort_p, tbl[k].valid, tbl[k].data, 1'b0,
           tbl[k].ew, tbl[k].ed, tbl[k].eb, tbl[k].et, tbl[k].edn, tbl[k].eo);
    end

    // FIFO full on record samples 2 and 3.
    trig_level = 12'h800; trig_edge = 1'b0; trig_auto = 1'b0; decim = 8'd0;
    step("full_arm",  1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
    step("full_7f0",  0, 0, 1, 12'h7F0, 0, 0, 12'h000, 1, 0, 0, 0);
    step("full_s1",   0, 0, 1, 12'h800, 0, 1, 12'h800, 1, 1, 0, 0);
    step("full_s2",   0, 0, 1, 12'h810, 1, 0, 12'h000, 1, 1, 0, 1);
    step("full_s3",   0, 0, 1, 12'h820, 1, 0, 12'h000, 1, 1, 0, 1);
    step("full_s4",   0, 0, 1, 12'h830, 0, 1, 12'h830, 0, 1, 1, 1);
    step("full_rearm",1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);

    // Abort together with arm mid-capture; overflow holds.
    step("ab_7f0",    0, 0, 1, 12'h7F0, 0, 0, 12'h000, 1, 0, 0, 0);
    step("ab_s1",     0, 0, 1, 12'h800, 0, 1, 12'h800, 1, 1, 0, 0);
    step("ab_s2full", 0, 0, 1, 12'h810, 1, 0, 12'h000, 1, 1, 0, 1);
    step("ab_abort",  1, 1, 1, 12'h820, 0, 0, 12'h000, 0, 0, 0, 1);
    step("ab_after1", 0, 0, 1, 12'h830, 0, 0, 12'h000, 0, 0, 0, 1);
    step("ab_after2", 0, 0, 1, 12'h7F0, 0, 0, 12'h000, 0, 0, 0, 1);

    // Asynchronous reset mid-record.
    step("rs_arm",    1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
    step("rs_7f0",    0, 0, 1, 12'h7F0, 0, 0, 12'h000, 1, 0, 0, 0);
    step("rs_s1",     0, 0, 1, 12'h800, 0, 1, 12'h800, 1, 1, 0, 0);
    step("rs_s2full", 0, 0, 1, 12'h810, 1, 0, 12'h000, 1, 1, 0, 1);
    step("rs_s3",     0, 0, 1, 12'h820, 0, 1, 12'h820, 1, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    check("rs_async", 0, 12'h000, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step("rs_idle",   0, 0, 1, 12'h830, 0, 0, 12'h000, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
